// File: rtl/z180_gpio_pkg.sv
// Shared definitions for the Z180 GPIO bank: register offsets, tick FSM
// state encoding and the input warm-up length.
package z180_gpio_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_IE   = 3'd2;
    localparam logic [2:0] REG_POL  = 3'd3;
    localparam logic [2:0] REG_ISR  = 3'd4;
    localparam logic [2:0] REG_OUT  = 3'd5;

    localparam int WARMUP_CYCLES = 3;

    typedef enum logic [1:0] {
        TICK_IDLE    = 2'd0,
        TICK_RD_HOLD = 2'd1,
        TICK_WR_ARM  = 2'd2,
        TICK_WR_HOLD = 2'd3
    } tick_state_e;

endpackage

// File: rtl/z180_gpio_bank_if.sv
// Z180 I/O bus as seen by a peripheral: address, strobes, write data and
// the read-data return path with its bus-drive enable.
interface z180_gpio_bank_if;
    logic [7:0] a;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_oe;

    modport master (output a, iorq_n, rd_n, wr_n, din, input dout, dout_oe);
    modport slave  (input a, iorq_n, rd_n, wr_n, din, output dout, dout_oe);
endinterface

// File: rtl/z180_iorq_tick_gen.sv
// Turns a Z180 I/O bus cycle into exactly one rd_tick or wr_tick, all
// evaluated on the falling edge of phi.
//
// state     | meaning
// IDLE      | no cycle in progress; read ticks here, write arms
// RD_HOLD   | read tick issued; wait for /IORQ to release
// WR_ARM    | write seen once; tick next edge if still active (din stable)
// WR_HOLD   | write tick issued; wait for /IORQ to release
module z180_iorq_tick_gen
    import z180_gpio_pkg::*;
(
    input  logic phi,
    input  logic reset_n,
    input  logic iorq_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic rd_tick,
    output logic wr_tick
);
    tick_state_e state_q, state_d;
    logic        bus_idle_seen_q;
    logic        io_rd, io_wr;

    assign io_rd = ~iorq_n & ~rd_n;
    assign io_wr = ~iorq_n & ~wr_n;

    always_ff @(negedge phi or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= TICK_IDLE;
            bus_idle_seen_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bus_idle_seen_q <= bus_idle_seen_q | iorq_n;
        end
    end

    // A cycle already running when reset releases must not tick, so IDLE
    // only accepts a new cycle once /IORQ has been seen inactive.
    always_comb begin
        state_d = state_q;
        rd_tick = 1'b0;
        wr_tick = 1'b0;
        case (state_q)
            TICK_IDLE: begin
                if (bus_idle_seen_q && io_rd) begin
                    rd_tick = 1'b1;
                    state_d = TICK_RD_HOLD;
                end else if (bus_idle_seen_q && io_wr) begin
                    state_d = TICK_WR_ARM;
                end
            end
            TICK_WR_ARM: begin
                if (io_wr) begin
                    wr_tick = 1'b1;
                    state_d = TICK_WR_HOLD;
                end else begin
                    state_d = TICK_IDLE;
                end
            end
            TICK_RD_HOLD, TICK_WR_HOLD: begin
                if (iorq_n) state_d = TICK_IDLE;
            end
            default: state_d = TICK_IDLE;
        endcase
    end

endmodule

// File: rtl/z180_gpio_bank.sv
// CHANNELS identical GPIO ports on the Z180 I/O bus, each with direction,
// edge polarity, interrupt enable and write-1-to-clear interrupt status.
module z180_gpio_bank
    import z180_gpio_pkg::*;
#(
    parameter int         CHANNELS  = 2,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hb0
) (
    input  logic                      phi,
    input  logic                      reset_n,
    z180_gpio_bank_if.slave           bus,
    input  logic [CHANNELS*WIDTH-1:0] pin_in,
    output logic [CHANNELS*WIDTH-1:0] pin_out,
    output logic [CHANNELS*WIDTH-1:0] pin_oe,
    output logic                      irq
);
    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    bank_t       out_q, out_d, dir_q, dir_d, ie_q, ie_d, pol_q, pol_d, isr_q, isr_d;
    bank_t       sync1_q, sync2_q, prev_q, edge_match, w1c;
    logic [1:0]  warm_q;
    logic        warm_done;
    logic [7:0]  offset, rdata, dout_q;
    logic [2:0]  ch_idx, reg_idx;
    logic [WIDTH-1:0] wdata;
    logic        hit, rd_tick, wr_tick, irq_q;

    assign offset  = bus.a - BASE_ADDR;
    assign hit     = offset < 8'(CHANNELS * 8);
    assign ch_idx  = offset[5:3];
    assign reg_idx = offset[2:0];
    assign wdata   = bus.din[WIDTH-1:0];

    z180_iorq_tick_gen u_tick (
        .phi     (phi),
        .reset_n (reset_n),
        .iorq_n  (bus.iorq_n),
        .rd_n    (bus.rd_n),
        .wr_n    (bus.wr_n),
        .rd_tick (rd_tick),
        .wr_tick (wr_tick)
    );

    assign warm_done = (warm_q == 2'(WARMUP_CYCLES));

    // Edges are taken from the synchronised pin, so output bits see them too.
    always_comb begin
        edge_match = '0;
        if (warm_done) begin
            for (int c = 0; c < CHANNELS; c++) begin
                edge_match[c] = (pol_q[c] & sync2_q[c] & ~prev_q[c]) |
                                (~pol_q[c] & ~sync2_q[c] & prev_q[c]);
            end
        end
    end

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        ie_d  = ie_q;
        pol_d = pol_q;
        w1c   = '0;
        if (wr_tick && hit) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_idx == 3'(c)) begin
                    case (reg_idx)
                        REG_DATA: out_d[c] = wdata;
                        REG_DIR:  dir_d[c] = wdata;
                        REG_IE:   ie_d[c]  = wdata;
                        REG_POL:  pol_d[c] = wdata;
                        REG_ISR:  w1c[c]   = wdata;
                        default:  ;
                    endcase
                end
            end
        end
        // A fresh edge beats a simultaneous clear of the same bit.
        isr_d = (isr_q & ~w1c) | edge_match;
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 3'(c)) begin
                case (reg_idx)
                    REG_DATA: rdata[WIDTH-1:0] = (dir_q[c] & out_q[c]) | (~dir_q[c] & sync2_q[c]);
                    REG_DIR:  rdata[WIDTH-1:0] = dir_q[c];
                    REG_IE:   rdata[WIDTH-1:0] = ie_q[c];
                    REG_POL:  rdata[WIDTH-1:0] = pol_q[c];
                    REG_ISR:  rdata[WIDTH-1:0] = isr_q[c];
                    REG_OUT:  rdata[WIDTH-1:0] = out_q[c];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(negedge phi or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            pol_q   <= '0;
            isr_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            irq_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            pol_q   <= pol_d;
            isr_q   <= isr_d;
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!warm_done) warm_q <= warm_q + 2'd1;
            irq_q   <= |(isr_q & ie_q);
            if (rd_tick && hit) dout_q <= rdata;
        end
    end

    assign pin_out     = out_q;
    assign pin_oe      = dir_q;
    assign irq         = irq_q;
    assign bus.dout    = dout_q;
    assign bus.dout_oe = ~bus.iorq_n & ~bus.rd_n & hit;

endmodule
